// File: rtl/alu_op_sequencer.sv
// Sequences {op,a,b} commands from a 2-deep queue onto an external 4-bit ALU and returns results.
// Optional operand chaining (cmd_chain port) is enabled by defining ALU_SEQ_CHAIN_EN.
module alu_op_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
`ifdef ALU_SEQ_CHAIN_EN
    input  logic       cmd_chain,
`endif
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_sel,
    input  logic [3:0] alu_y,
    input  logic       alu_cout,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_y,
    output logic       res_cout,
    output logic       res_err,
    output logic       busy
);

    typedef enum logic [1:0] {StIdle, StDrive, StHold} state_e;

    state_e     r_state, w_state_nxt;
    logic [2:0] r_fifo_op [2];
    logic [3:0] r_fifo_a  [2];
    logic [3:0] r_fifo_b  [2];
    logic       r_wr_ptr, r_rd_ptr;
    logic [1:0] r_count;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic [3:0] r_alu_a, w_alu_a_nxt, r_alu_b, w_alu_b_nxt;
    logic [2:0] r_alu_sel, w_alu_sel_nxt;
    logic [3:0] r_res_y, w_res_y_nxt;
    logic       r_res_cout, w_res_cout_nxt, r_res_err, w_res_err_nxt;
    logic       r_res_valid, w_res_valid_nxt;
    logic       w_push, w_pop, w_load;
    logic [2:0] w_head_op;
    logic [3:0] w_head_a;

    assign cmd_ready = (r_count != 2'd2);
    assign w_push    = cmd_valid && cmd_ready;
    assign busy      = (r_state != StIdle) || (r_count != 2'd0);
    assign w_head_op = r_fifo_op[r_rd_ptr];

`ifdef ALU_SEQ_CHAIN_EN
    logic       r_fifo_chain [2];
    logic [3:0] r_chain_y;
    logic       w_capture;

    assign w_capture = (r_state == StDrive) && (r_cnt <= 4'd1);
    assign w_head_a  = r_fifo_chain[r_rd_ptr] ? r_chain_y : r_fifo_a[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain_y <= 4'd0;
        end else if (w_capture) begin
            r_chain_y <= alu_y;
        end
        if (w_push) begin
            r_fifo_chain[r_wr_ptr] <= cmd_chain;
        end
    end
`else
    assign w_head_a = r_fifo_a[r_rd_ptr];
`endif

    // Load from the queue head happens from IDLE or straight out of HOLD (back-to-back).
    assign w_load = (r_count != 2'd0) &&
                    ((r_state == StIdle) || ((r_state == StHold) && res_ready));

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_alu_a_nxt     = r_alu_a;
        w_alu_b_nxt     = r_alu_b;
        w_alu_sel_nxt   = r_alu_sel;
        w_res_y_nxt     = r_res_y;
        w_res_cout_nxt  = r_res_cout;
        w_res_err_nxt   = r_res_err;
        w_res_valid_nxt = r_res_valid;
        w_pop           = 1'b0;
        case (r_state)
            StIdle: ;
            StDrive: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_cnt_nxt       = 4'd0;
                    w_res_y_nxt     = alu_y;
                    w_res_cout_nxt  = alu_cout;
                    w_res_err_nxt   = 1'b0;
                    w_res_valid_nxt = 1'b1;
                    w_state_nxt     = StHold;
                end
            end
            StHold: begin
                if (res_ready) begin
                    w_res_valid_nxt = 1'b0;
                    w_state_nxt     = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
        if (w_load) begin
            w_pop = 1'b1;
            if (w_head_op == 3'b111) begin
                w_res_y_nxt     = 4'd0;
                w_res_cout_nxt  = 1'b0;
                w_res_err_nxt   = 1'b1;
                w_res_valid_nxt = 1'b1;
                w_state_nxt     = StHold;
            end else begin
                w_alu_a_nxt   = w_head_a;
                w_alu_b_nxt   = r_fifo_b[r_rd_ptr];
                w_alu_sel_nxt = w_head_op;
                w_cnt_nxt     = 4'(SETTLE_CYCLES);
                w_state_nxt   = StDrive;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_op[r_wr_ptr] <= cmd_op;
            r_fifo_a[r_wr_ptr]  <= cmd_a;
            r_fifo_b[r_wr_ptr]  <= cmd_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_count     <= 2'd0;
            r_cnt       <= 4'd0;
            r_alu_a     <= 4'd0;
            r_alu_b     <= 4'd0;
            r_alu_sel   <= 3'd0;
            r_res_y     <= 4'd0;
            r_res_cout  <= 1'b0;
            r_res_err   <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_alu_a     <= w_alu_a_nxt;
            r_alu_b     <= w_alu_b_nxt;
            r_alu_sel   <= w_alu_sel_nxt;
            r_res_y     <= w_res_y_nxt;
            r_res_cout  <= w_res_cout_nxt;
            r_res_err   <= w_res_err_nxt;
            r_res_valid <= w_res_valid_nxt;
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_sel   = r_alu_sel;
    assign res_y     = r_res_y;
    assign res_cout  = r_res_cout;
    assign res_err   = r_res_err;
    assign res_valid = r_res_valid;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: a SETTLE_CYCLES=1 instance for function/flow control,
// a SETTLE_CYCLES=4 instance for reset mid-operation. Chaining checked when ALU_SEQ_CHAIN_EN set.
module tb_alu_op_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance 0: SETTLE_CYCLES = 1
    logic       rst, cmd_valid, cmd_ready, cmd_chain;
    logic [2:0] cmd_op, alu_sel;
    logic [3:0] cmd_a, cmd_b, alu_a, alu_b, alu_y, res_y;
    logic       alu_cout, res_valid, res_ready, res_cout, res_err, busy;

    // Instance 1: SETTLE_CYCLES = 4
    logic       rst1, cmd_valid1, cmd_ready1;
    logic [2:0] cmd_op1, alu_sel1;
    logic [3:0] cmd_a1, cmd_b1, alu_a1, alu_b1, alu_y1, res_y1;
    logic       alu_cout1, res_valid1, res_ready1, res_cout1, res_err1, busy1;
`ifdef ALU_SEQ_CHAIN_EN
    logic       cmd_chain1;
`endif

    alu_op_sequencer #(.SETTLE_CYCLES(1)) u_dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
`ifdef ALU_SEQ_CHAIN_EN
        .cmd_chain(cmd_chain),
`endif
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_y(alu_y), .alu_cout(alu_cout),
        .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y), .res_cout(res_cout),
        .res_err(res_err), .busy(busy)
    );

    alu_op_sequencer #(.SETTLE_CYCLES(4)) u_dut4 (
        .clk(clk), .rst(rst1), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_op(cmd_op1), .cmd_a(cmd_a1), .cmd_b(cmd_b1),
`ifdef ALU_SEQ_CHAIN_EN
        .cmd_chain(cmd_chain1),
`endif
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_sel(alu_sel1), .alu_y(alu_y1), .alu_cout(alu_cout1),
        .res_valid(res_valid1), .res_ready(res_ready1), .res_y(res_y1), .res_cout(res_cout1),
        .res_err(res_err1), .busy(busy1)
    );

    // ALU model: sel 0 add, sel 1 subtract, others AND
    always_comb begin
        case (alu_sel)
            3'd0:    {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
            3'd1:    {alu_cout, alu_y} = {1'b0, alu_a} - {1'b0, alu_b};
            default: {alu_cout, alu_y} = {1'b0, alu_a & alu_b};
        endcase
    end

    always_comb begin
        case (alu_sel1)
            3'd0:    {alu_cout1, alu_y1} = {1'b0, alu_a1} + {1'b0, alu_b1};
            3'd1:    {alu_cout1, alu_y1} = {1'b0, alu_a1} - {1'b0, alu_b1};
            default: {alu_cout1, alu_y1} = {1'b0, alu_a1 & alu_b1};
        endcase
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic chain);
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_chain = chain;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Waits (bounded) for a result, checks it, then lets the handshake edge pass (res_ready=1).
    task automatic wait_res(input string tag, input logic [3:0] y, input logic err);
        int n = 0;
        while (!res_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 8'(res_valid), 8'd1);
        check({tag, "_y"}, 8'(res_y), 8'(y));
        check({tag, "_err"}, 8'(res_err), 8'(err));
        tick();
    endtask

    initial begin
        int seen;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_a = 4'd0; cmd_b = 4'd0;
        cmd_chain = 1'b0; res_ready = 1'b1;
        rst1 = 1'b1; cmd_valid1 = 1'b0; cmd_op1 = 3'd0; cmd_a1 = 4'd0; cmd_b1 = 4'd0;
        res_ready1 = 1'b1;
`ifdef ALU_SEQ_CHAIN_EN
        cmd_chain1 = 1'b0;
`endif
        tick(); tick();
        rst = 1'b0; rst1 = 1'b0;

        // Reset state
        check("rst_valid", 8'(res_valid), 8'd0);
        check("rst_ready", 8'(cmd_ready), 8'd1);
        check("rst_busy", 8'(busy), 8'd0);
        check("rst_alu_a", 8'(alu_a), 8'd0);
        check("rst_alu_sel", 8'(alu_sel), 8'd0);
        check("rst_res_y", 8'(res_y), 8'd0);
        check("rst_res_err", 8'(res_err), 8'd0);

        // Single op with exact latency: 3+5
        push(3'd0, 4'd3, 4'd5, 1'b0);
        check("s1_valid_t", 8'(res_valid), 8'd0);
        check("s1_busy", 8'(busy), 8'd1);
        tick();
        check("s1_alu_a", 8'(alu_a), 8'd3);
        check("s1_alu_b", 8'(alu_b), 8'd5);
        check("s1_valid_t1", 8'(res_valid), 8'd0);
        tick();
        check("s1_valid_t2", 8'(res_valid), 8'd1);
        check("s1_y", 8'(res_y), 8'd8);
        check("s1_cout", 8'(res_cout), 8'd0);
        check("s1_err", 8'(res_err), 8'd0);
        tick();
        check("s1_done_valid", 8'(res_valid), 8'd0);
        check("s1_done_busy", 8'(busy), 8'd0);

        // Overflow then back-to-back subtract: 9+8 -> 1 carry, 2-3 -> 15
        push(3'd0, 4'd9, 4'd8, 1'b0);
        push(3'd1, 4'd2, 4'd3, 1'b0);
        check("b2b_alu_a0", 8'(alu_a), 8'd9);
        tick();
        check("b2b_valid0", 8'(res_valid), 8'd1);
        check("b2b_y0", 8'(res_y), 8'd1);
        check("b2b_cout0", 8'(res_cout), 8'd1);
        tick();
        check("b2b_gap_valid", 8'(res_valid), 8'd0);
        check("b2b_alu_sel1", 8'(alu_sel), 8'd1);
        check("b2b_alu_a1", 8'(alu_a), 8'd2);
        tick();
        check("b2b_valid1", 8'(res_valid), 8'd1);
        check("b2b_y1", 8'(res_y), 8'd15);
        tick();
        check("b2b_idle", 8'(busy), 8'd0);

        // Illegal op: alu_* keep sel=1, a=2, b=3 from previous command
        push(3'd7, 4'd1, 4'd1, 1'b0);
        tick();
        check("ill_valid", 8'(res_valid), 8'd1);
        check("ill_err", 8'(res_err), 8'd1);
        check("ill_y", 8'(res_y), 8'd0);
        check("ill_cout", 8'(res_cout), 8'd0);
        check("ill_alu_sel", 8'(alu_sel), 8'd1);
        check("ill_alu_a", 8'(alu_a), 8'd2);
        check("ill_alu_b", 8'(alu_b), 8'd3);
        tick();
        push(3'd0, 4'd6, 4'd1, 1'b0);
        wait_res("ill_next", 4'd7, 1'b0);

        // Backpressure and full queue
        res_ready = 1'b0;
        push(3'd0, 4'd1, 4'd1, 1'b0);
        push(3'd0, 4'd2, 4'd2, 1'b0);
        push(3'd0, 4'd4, 4'd4, 1'b0);
        check("bp_full_ready", 8'(cmd_ready), 8'd0);
        check("bp_valid", 8'(res_valid), 8'd1);
        check("bp_y", 8'(res_y), 8'd2);
        cmd_op = 3'd0; cmd_a = 4'd7; cmd_b = 4'd2; cmd_valid = 1'b1;
        tick(); tick();
        check("bp_stall_ready", 8'(cmd_ready), 8'd0);
        check("bp_stall_y", 8'(res_y), 8'd2);
        check("bp_stall_valid", 8'(res_valid), 8'd1);
        check("bp_stall_busy", 8'(busy), 8'd1);
        res_ready = 1'b1;
        tick();
        check("bp_free_ready", 8'(cmd_ready), 8'd1);
        check("bp_free_valid", 8'(res_valid), 8'd0);
        tick();
        cmd_valid = 1'b0;
        wait_res("bp_b", 4'd4, 1'b0);
        wait_res("bp_c", 4'd8, 1'b0);
        wait_res("bp_d", 4'd9, 1'b0);
        check("bp_end_busy", 8'(busy), 8'd0);

`ifdef ALU_SEQ_CHAIN_EN
        push(3'd0, 4'd3, 4'd5, 1'b0);
        push(3'd0, 4'd0, 4'd2, 1'b1);
        wait_res("chain0", 4'd8, 1'b0);
        wait_res("chain1", 4'd10, 1'b0);
`endif

        // Reset mid-DRIVE on the SETTLE_CYCLES=4 instance
        cmd_op1 = 3'd0; cmd_a1 = 4'd1; cmd_b1 = 4'd1; cmd_valid1 = 1'b1;
        tick();
        cmd_a1 = 4'd2; cmd_b1 = 4'd2;
        tick();
        cmd_valid1 = 1'b0;
        tick();
        check("r4_busy", 8'(busy1), 8'd1);
        check("r4_valid", 8'(res_valid1), 8'd0);
        check("r4_alu_a", 8'(alu_a1), 8'd1);
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        check("r4_rst_valid", 8'(res_valid1), 8'd0);
        check("r4_rst_busy", 8'(busy1), 8'd0);
        check("r4_rst_ready", 8'(cmd_ready1), 8'd1);
        check("r4_rst_alu_a", 8'(alu_a1), 8'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (res_valid1 || busy1) seen++;
        end
        check("r4_no_result", 8'(seen), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
